// File: rtl/alarm_pkg.sv
// Shared alarm-system types and constants.
// Holds the system FSM state encoding, the passcode controller state encoding,
// the default clock rate, and a helper that decides when digits are accepted.
package alarm_pkg;

  // States of the alarm system FSM, which this controller only observes.
  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_SET,
    STATE_TRIGGER,
    STATE_ALERT
  } fsm_state_t;

  // Default clock rate in Hz. It doubles as the number of prescaler counts per second.
  localparam int CLK_HZ = 50_000_000;

  // States of the passcode controller.
  typedef enum logic [2:0] {
    PC_ENTRY,
    PC_CHECK,
    PC_LOCKOUT,
    PC_PROG_NEW,
    PC_PROG_CONFIRM
  } pc_state_t;

  // Passcode entry is only meaningful while the system is armed or alarming.
  // Code programming is only allowed while the system is disarmed.
  function automatic logic digit_accepted(pc_state_t pc, fsm_state_t sys);
    logic ok;
    ok = 1'b0;
    case (pc)
      PC_ENTRY:        ok = (sys != STATE_IDLE);
      PC_PROG_NEW,
      PC_PROG_CONFIRM: ok = (sys == STATE_IDLE);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/seconds_tick.sv
// Seconds prescaler that emits a one-cycle tick every TICK_HZ enabled clocks.
// A synchronous restart parks the count at zero, so the first tick after a
// restart arrives exactly TICK_HZ enabled cycles later. The system FSM
// countdown can reuse this block.
module seconds_tick #(
  parameter int TICK_HZ = alarm_pkg::CLK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_HZ - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  // The tick fires on the final count of each second. Restart suppresses it.
  assign w_wrap = i_enable && !i_restart && (r_count == LAST);
  assign o_tick = w_wrap;

  // Prescaler counter: hold at zero on restart, wrap at the end of each second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_restart) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/passcode_controller.sv
// Keypad passcode controller.
// Buffers digits and checks them against the stored code. It pulses
// passcode_correct or passcode_wrong for the alarm FSM. Too many wrong tries
// start a timed lockout. While the system is idle, it runs a two-pass flow to
// program a new code.
module passcode_controller
  import alarm_pkg::*;
#(
  parameter int                    CODE_LEN     = 4,
  parameter int                    MAX_ATTEMPTS = 3,
  parameter int                    CLK_HZ       = alarm_pkg::CLK_HZ,
  parameter int                    LOCKOUT_S    = 10,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  fsm_state_t system_state,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       enter,
  input  logic       clear,
  input  logic       program_req,
  output logic       passcode_correct,
  output logic       passcode_wrong,
  output logic       code_updated,
  output logic [2:0] entry_count,
  output logic [1:0] attempts_left,
  output logic       locked,
  output logic [7:0] lockout_seconds,
  output logic       programming
);

  localparam int         BW        = 4 * CODE_LEN;
  localparam logic [2:0] FULL      = 3'(CODE_LEN);
  localparam logic [1:0] ATT_MAX   = 2'(MAX_ATTEMPTS);
  localparam logic [7:0] LOCK_SECS = 8'(LOCKOUT_S);

  // Registered state.
  pc_state_t     r_state;
  fsm_state_t    r_sys_prev;
  logic [BW-1:0] r_buf;
  logic [2:0]    r_count;
  logic [BW-1:0] r_code;
  logic [BW-1:0] r_cand;
  logic [1:0]    r_attempts;
  logic [7:0]    r_lock_secs;
  logic          r_correct;
  logic          r_wrong;
  logic          r_updated;

  // Next-state values.
  pc_state_t     w_state_next;
  logic [BW-1:0] w_buf_next;
  logic [2:0]    w_count_next;
  logic [BW-1:0] w_code_next;
  logic [BW-1:0] w_cand_next;
  logic [1:0]    w_attempts_next;
  logic [7:0]    w_secs_next;
  logic          w_correct_next;
  logic          w_wrong_next;
  logic          w_updated_next;

  // Decoded conditions.
  logic                w_sys_changed;
  logic                w_in_prog;
  logic                w_full;
  logic                w_digit_ok;
  logic                w_locked;
  logic                w_restart;
  logic                w_tick;
  logic [CODE_LEN-1:0] w_nib_eq_code;
  logic [CODE_LEN-1:0] w_nib_eq_cand;
  logic                w_match_code;
  logic                w_match_cand;

  assign w_sys_changed = (system_state != r_sys_prev);
  assign w_in_prog     = (r_state == PC_PROG_NEW) || (r_state == PC_PROG_CONFIRM);
  assign w_full        = (r_count == FULL);
  assign w_digit_ok    = digit_valid && digit_accepted(r_state, system_state);
  assign w_locked      = (r_state == PC_LOCKOUT);

  // Compare the buffer with the stored code and the candidate code one digit at a time.
  // A match also needs a full buffer, so leading zeros cannot match a short entry.
  for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_nibble
    assign w_nib_eq_code[gi] = (r_buf[4*gi +: 4] == r_code[4*gi +: 4]);
    assign w_nib_eq_cand[gi] = (r_buf[4*gi +: 4] == r_cand[4*gi +: 4]);
  end

  assign w_match_code = w_full && (&w_nib_eq_code);
  assign w_match_cand = w_full && (&w_nib_eq_cand);

  // Keep the prescaler at zero outside lockout, so every lockout starts on a full second.
  assign w_restart = !w_locked;

  seconds_tick #(
    .TICK_HZ (CLK_HZ)
  ) u_seconds_tick (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (w_locked),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Controller next-state logic.
  // Strobe priority is: system state change, then clear, then enter, then
  // program_req, then digit. Lower-priority strobes in the same cycle are dropped.
  always_comb begin
    w_state_next    = r_state;
    w_buf_next      = r_buf;
    w_count_next    = r_count;
    w_code_next     = r_code;
    w_cand_next     = r_cand;
    w_attempts_next = r_attempts;
    w_secs_next     = r_lock_secs;
    w_correct_next  = 1'b0;
    w_wrong_next    = 1'b0;
    w_updated_next  = 1'b0;

    case (r_state)
      PC_LOCKOUT: begin
        // Ignore all strobes. Leave lockout when the last second expires.
        if (w_tick) begin
          w_secs_next = r_lock_secs - 8'd1;
          if (r_lock_secs == 8'd1) begin
            w_state_next    = PC_ENTRY;
            w_attempts_next = ATT_MAX;
          end
        end
      end

      PC_CHECK: begin
        // This one-cycle evaluation state registers the verdict pulse.
        w_buf_next   = '0;
        w_count_next = '0;
        w_state_next = PC_ENTRY;
        if (w_match_code) begin
          w_correct_next  = 1'b1;
          w_attempts_next = ATT_MAX;
        end else begin
          w_wrong_next = 1'b1;
          if (r_attempts > 2'd1) begin
            w_attempts_next = r_attempts - 2'd1;
          end else begin
            w_attempts_next = 2'd0;
            w_secs_next     = LOCK_SECS;
            w_state_next    = PC_LOCKOUT;
          end
        end
      end

      default: begin
        if (w_sys_changed) begin
          // Drop any partial entry made under the old system state.
          // Leaving idle also abandons programming.
          w_buf_next   = '0;
          w_count_next = '0;
          if (w_in_prog && (system_state != STATE_IDLE)) begin
            w_state_next = PC_ENTRY;
          end
        end else if (clear) begin
          w_buf_next   = '0;
          w_count_next = '0;
          if (w_in_prog) begin
            w_state_next = PC_ENTRY;
          end
        end else if (enter) begin
          case (r_state)
            PC_ENTRY: begin
              // An empty submit is not an attempt.
              if (r_count != 3'd0) begin
                w_state_next = PC_CHECK;
              end
            end
            PC_PROG_NEW: begin
              w_buf_next   = '0;
              w_count_next = '0;
              if (w_full) begin
                w_cand_next  = r_buf;
                w_state_next = PC_PROG_CONFIRM;
              end else begin
                w_wrong_next = 1'b1;
                w_state_next = PC_ENTRY;
              end
            end
            PC_PROG_CONFIRM: begin
              w_buf_next   = '0;
              w_count_next = '0;
              w_state_next = PC_ENTRY;
              if (w_match_cand) begin
                w_code_next    = r_cand;
                w_updated_next = 1'b1;
              end else begin
                w_wrong_next = 1'b1;
              end
            end
            default: begin
              w_state_next = PC_ENTRY;
            end
          endcase
        end else if (program_req && (r_state == PC_ENTRY) && (system_state == STATE_IDLE)) begin
          w_buf_next   = '0;
          w_count_next = '0;
          w_state_next = PC_PROG_NEW;
        end else if (w_digit_ok && !w_full) begin
          // New digits enter at the LS nibble. Extra digits beyond a full code are dropped.
          w_buf_next   = {r_buf[BW-5:0], digit_in};
          w_count_next = r_count + 3'd1;
        end
      end
    endcase
  end

  // State register with asynchronous reset to the power-on defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PC_ENTRY;
      r_sys_prev  <= STATE_IDLE;
      r_buf       <= '0;
      r_count     <= '0;
      r_code      <= DEFAULT_CODE;
      r_cand      <= '0;
      r_attempts  <= ATT_MAX;
      r_lock_secs <= '0;
      r_correct   <= 1'b0;
      r_wrong     <= 1'b0;
      r_updated   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sys_prev  <= system_state;
      r_buf       <= w_buf_next;
      r_count     <= w_count_next;
      r_code      <= w_code_next;
      r_cand      <= w_cand_next;
      r_attempts  <= w_attempts_next;
      r_lock_secs <= w_secs_next;
      r_correct   <= w_correct_next;
      r_wrong     <= w_wrong_next;
      r_updated   <= w_updated_next;
    end
  end

  assign passcode_correct = r_correct;
  assign passcode_wrong   = r_wrong;
  assign code_updated     = r_updated;
  assign entry_count      = r_count;
  assign attempts_left    = r_attempts;
  assign locked           = w_locked;
  assign lockout_seconds  = r_lock_secs;
  assign programming      = w_in_prog;

endmodule

// File: tb/tb_passcode_controller.sv
// Testbench for passcode_controller.
// A behavioural model tracks the digit queue, stored code, attempts and
// lockout deadline. Stimulus tasks push each expected pulse into a scoreboard,
// and a forked monitor pops it when the DUT raises a pulse.
module tb_passcode_controller;
  import alarm_pkg::*;

  localparam int CLK_HZ   = 10;
  localparam int LOCK_S   = 2;
  localparam int MAX_ATT  = 3;
  localparam int CODE_LEN = 4;
  localparam int LOCK_CYC = CLK_HZ * LOCK_S;

  logic       clk = 1'b0;
  logic       rst;
  fsm_state_t system_state;
  logic [3:0] digit_in;
  logic       digit_valid, enter, clear, program_req;
  logic       passcode_correct, passcode_wrong, code_updated;
  logic [2:0] entry_count;
  logic [1:0] attempts_left;
  logic       locked;
  logic [7:0] lockout_seconds;
  logic       programming;

  passcode_controller #(
    .CODE_LEN     (CODE_LEN),
    .MAX_ATTEMPTS (MAX_ATT),
    .CLK_HZ       (CLK_HZ),
    .LOCKOUT_S    (LOCK_S),
    .DEFAULT_CODE (16'h1234)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .system_state     (system_state),
    .digit_in         (digit_in),
    .digit_valid      (digit_valid),
    .enter            (enter),
    .clear            (clear),
    .program_req      (program_req),
    .passcode_correct (passcode_correct),
    .passcode_wrong   (passcode_wrong),
    .code_updated     (code_updated),
    .entry_count      (entry_count),
    .attempts_left    (attempts_left),
    .locked           (locked),
    .lockout_seconds  (lockout_seconds),
    .programming      (programming)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry. kind: 0 = correct, 1 = wrong, 2 = code updated.
  typedef struct {
    int kind;
    int at;
  } exp_t;
  exp_t sb[$];

  // Reference model state.
  int         m_digits[$];
  int         m_code[CODE_LEN];
  int         m_cand[CODE_LEN];
  int         m_att;
  int         m_phase;     // 0 = normal entry, 1 = new code, 2 = confirm
  bit         m_lock;
  int         m_lock_end;  // first cycle in which the controller is unlocked
  fsm_state_t m_sys;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  function automatic bit matches_code();
    if (m_digits.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++) if (m_digits[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit matches_cand();
    if (m_digits.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++) if (m_digits[i] != m_cand[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = i + 1;
    m_att   = MAX_ATT;
    m_phase = 0;
    m_lock  = 1'b0;
  endtask

  // When the lockout deadline passes, the controller unlocks and refills attempts.
  task automatic model_time(input int now);
    if (m_lock && now >= m_lock_end) begin
      m_lock = 1'b0;
      m_att  = MAX_ATT;
    end
  endtask

  // Apply one strobe cycle driven during cycle n.
  task automatic model_apply(input bit dv, input int d, input bit en, input bit cl,
                             input bit pr, input int n);
    bit ok;
    if (m_lock) return;
    if (cl) begin
      m_digits.delete();
      m_phase = 0;
      return;
    end
    if (en) begin
      if (m_phase == 0) begin
        if (m_digits.size() == 0) return;
        if (matches_code()) begin
          push_exp(0, n + 2);
          m_att = MAX_ATT;
        end else begin
          push_exp(1, n + 2);
          m_att--;
          if (m_att == 0) begin
            m_lock     = 1'b1;
            m_lock_end = n + 2 + LOCK_CYC;
          end
        end
      end else if (m_phase == 1) begin
        if (m_digits.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_cand[i] = m_digits[i];
          m_phase = 2;
        end else begin
          push_exp(1, n + 1);
          m_phase = 0;
        end
      end else begin
        if (matches_cand()) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_cand[i];
          push_exp(2, n + 1);
        end else begin
          push_exp(1, n + 1);
        end
        m_phase = 0;
      end
      m_digits.delete();
      return;
    end
    if (pr && m_phase == 0 && m_sys == STATE_IDLE) begin
      m_phase = 1;
      m_digits.delete();
      return;
    end
    if (dv) begin
      ok = (m_phase == 0) ? (m_sys != STATE_IDLE) : (m_sys == STATE_IDLE);
      if (ok && m_digits.size() < CODE_LEN) m_digits.push_back(d);
    end
  endtask

  // Compare the DUT's visible status against the model at the next falling edge.
  task automatic status();
    int secs;
    @(negedge clk);
    model_time(cyc);
    secs = m_lock ? (m_lock_end - cyc + CLK_HZ - 1) / CLK_HZ : 0;
    check("entry_count", int'(entry_count), m_digits.size());
    check("attempts_left", int'(attempts_left), m_att);
    check("locked", int'(locked), int'(m_lock));
    check("lockout_seconds", int'(lockout_seconds), secs);
    check("programming", int'(programming), int'(m_phase != 0));
  endtask

  // Drive one strobe cycle. After an enter, wait an extra clock so any evaluation completes.
  task automatic op(input bit dv, input int d, input bit en, input bit cl, input bit pr);
    int n;
    @(posedge clk);
    #1;
    n = cyc;
    model_time(n);
    model_apply(dv, d, en, cl, pr, n);
    digit_valid = dv;
    digit_in    = 4'(d);
    enter       = en;
    clear       = cl;
    program_req = pr;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    enter       = 1'b0;
    clear       = 1'b0;
    program_req = 1'b0;
    if (en) @(posedge clk);
    status();
  endtask

  task automatic idle();
    op(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic type4(input int a, input int b, input int c, input int d);
    op(1'b1, a, 1'b0, 1'b0, 1'b0);
    op(1'b1, b, 1'b0, 1'b0, 1'b0);
    op(1'b1, c, 1'b0, 1'b0, 1'b0);
    op(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_enter();
    op(1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_sys(input fsm_state_t s);
    @(posedge clk);
    #1;
    model_time(cyc);
    if (s != m_sys && !m_lock) begin
      m_digits.delete();
      if (m_phase != 0 && s != STATE_IDLE) m_phase = 0;
    end
    m_sys        = s;
    system_state = s;
    @(posedge clk);
    #1;
    status();
  endtask

  // Assert reset between clock edges and confirm that the outputs clear at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_attempts", int'(attempts_left), MAX_ATT);
    check("rst_count", int'(entry_count), 0);
    check("rst_secs", int'(lockout_seconds), 0);
    check("rst_prog", int'(programming), 0);
    check("rst_pulses", int'({passcode_correct, passcode_wrong, code_updated}), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();
  endtask

  // Monitor: pair every DUT pulse with the oldest expected pulse.
  task automatic run_monitor();
    exp_t e;
    int   kind;
    int   npulse;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (sb.size() > 0 && sb[0].at < cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_pulse: got none expected kind %0d at cycle %0d", e.kind, e.at);
        end
        npulse = int'(passcode_correct) + int'(passcode_wrong) + int'(code_updated);
        if (npulse != 0) begin
          kind = passcode_correct ? 0 : (passcode_wrong ? 1 : 2);
          $display("cycle %0d pulse kind=%0d (0=correct 1=wrong 2=updated)", cyc, kind);
          if (npulse > 1) begin
            check("pulse_onehot", npulse, 1);
          end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none", kind, cyc);
          end else begin
            e = sb.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.at);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int wait_n;
    int code_copy[CODE_LEN];

    rst          = 1'b1;
    system_state = STATE_SET;
    m_sys        = STATE_SET;
    digit_in     = 4'd0;
    digit_valid  = 1'b0;
    enter        = 1'b0;
    clear        = 1'b0;
    program_req  = 1'b0;
    model_reset();
    fork
      run_monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_attempts", int'(attempts_left), MAX_ATT);
    check("reset_locked", int'(locked), 0);
    check("reset_count", int'(entry_count), 0);
    rst = 1'b0;
    idle();
    idle();

    // Correct default code, then an empty enter that must not count as an attempt.
    type4(1, 2, 3, 4);
    press_enter();
    press_enter();

    // Three wrong codes cause a lockout. Input during the lockout is ignored.
    for (int k = 0; k < 3; k++) begin
      type4(9, 9, 9, 9);
      press_enter();
    end
    check("lockout_entered", int'(locked), 1);
    check("lockout_secs_start", int'(lockout_seconds), LOCK_S);
    type4(1, 2, 3, 4);
    press_enter();
    wait_n = 0;
    while (m_lock && wait_n < 3 * LOCK_CYC) begin
      idle();
      wait_n++;
    end
    check("lockout_released", int'(locked), 0);
    check("lockout_attempts_refill", int'(attempts_left), MAX_ATT);

    // Entering six digits keeps only the first four. A short entry is wrong.
    type4(1, 2, 3, 4);
    op(1'b1, 5, 1'b0, 1'b0, 1'b0);
    op(1'b1, 6, 1'b0, 1'b0, 1'b0);
    check("saturate_count", int'(entry_count), CODE_LEN);
    press_enter();
    op(1'b1, 1, 1'b0, 1'b0, 1'b0);
    op(1'b1, 2, 1'b0, 1'b0, 1'b0);
    press_enter();
    type4(1, 2, 3, 4);
    press_enter();

    // Program 5678, then verify the new and old codes while armed.
    set_sys(STATE_IDLE);
    op(1'b0, 0, 1'b0, 1'b0, 1'b1);
    type4(5, 6, 7, 8);
    press_enter();
    type4(5, 6, 7, 8);
    press_enter();
    set_sys(STATE_SET);
    type4(5, 6, 7, 8);
    press_enter();
    type4(1, 2, 3, 4);
    press_enter();

    // Leaving idle aborts programming. Then test enter+digit and clear+enter in one cycle.
    set_sys(STATE_IDLE);
    op(1'b0, 0, 1'b0, 1'b0, 1'b1);
    type4(1, 1, 1, 1);
    press_enter();
    op(1'b1, 1, 1'b0, 1'b0, 1'b0);
    set_sys(STATE_SET);
    check("prog_abort", int'(programming), 0);
    type4(5, 6, 7, 8);
    press_enter();
    op(1'b1, 5, 1'b0, 1'b0, 1'b0);
    op(1'b1, 6, 1'b0, 1'b0, 1'b0);
    op(1'b1, 7, 1'b0, 1'b0, 1'b0);
    op(1'b1, 8, 1'b1, 1'b0, 1'b0);
    type4(5, 6, 7, 8);
    op(1'b0, 0, 1'b1, 1'b1, 1'b0);

    // Reset during lockout, and reset after a code change, must restore defaults.
    for (int k = 0; k < 3; k++) begin
      type4(0, 0, 0, 0);
      press_enter();
    end
    do_reset();
    set_sys(STATE_IDLE);
    op(1'b0, 0, 1'b0, 1'b0, 1'b1);
    type4(4, 3, 2, 1);
    press_enter();
    type4(4, 3, 2, 1);
    press_enter();
    set_sys(STATE_SET);
    do_reset();
    type4(1, 2, 3, 4);
    press_enter();

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(99);
      if (r < 30) begin
        op(1'b1, $urandom_range(9), 1'b0, 1'b0, 1'b0);
      end else if (r < 42) begin
        for (int i = 0; i < CODE_LEN; i++) code_copy[i] = m_code[i];
        for (int i = 0; i < CODE_LEN; i++) op(1'b1, code_copy[i], 1'b0, 1'b0, 1'b0);
      end else if (r < 56) begin
        press_enter();
      end else if (r < 60) begin
        op(1'b0, 0, 1'b0, 1'b1, 1'b0);
      end else if (r < 64) begin
        op(1'b1, $urandom_range(9), 1'b1, 1'b0, 1'b0);
      end else if (r < 67) begin
        op(1'b0, 0, 1'b1, 1'b1, 1'b0);
      end else if (r < 73) begin
        set_sys(fsm_state_t'($urandom_range(3)));
      end else if (r < 80) begin
        op(1'b0, 0, 1'b0, 1'b0, 1'b1);
      end else if (r < 85 && m_phase == 2) begin
        for (int i = 0; i < CODE_LEN; i++) code_copy[i] = m_cand[i];
        for (int i = 0; i < CODE_LEN; i++) op(1'b1, code_copy[i], 1'b0, 1'b0, 1'b0);
      end else begin
        idle();
      end
    end

    repeat (4) idle();
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
